// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: address-path sequencer (weight fetch, IA sweep, OA valid).
// Optional build macro ADDR_SEQ_STALL_EN adds a stall input that pauses SCAN.
`timescale 1ns/1ps
module addr_seq_ctrl #(
    parameter int RAM_ADDR_W = 5,
    parameter int RAM_DEPTH  = 32,
    parameter int ARB_W      = 3,
    parameter int ARB_SEL    = 8,
    parameter int WTS_ROM_AW = 10,
    parameter int NUM_W      = 10,
    parameter int PIPE_LAT   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WTS_ROM_AW-1:0] wts_base,
    input  logic [NUM_W-1:0]      num_wts,
`ifdef ADDR_SEQ_STALL_EN
    input  logic                  stall,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  wts_rom_rd_en,
    output logic [WTS_ROM_AW-1:0] wts_rom_addr,
    output logic                  addr_rf_enable,
    output logic                  addr_bram_enable,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic [ARB_W-1:0]      arbiter_ctrl,
    output logic                  oa_valid
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [RAM_ADDR_W-1:0] RAM_LAST = RAM_ADDR_W'(RAM_DEPTH - 1);
    localparam logic [RAM_ADDR_W-1:0] RAM_ONE  = RAM_ADDR_W'(1);
    localparam logic [ARB_W-1:0]      ARB_LAST = ARB_W'(ARB_SEL - 1);
    localparam logic [ARB_W-1:0]      ARB_ONE  = ARB_W'(1);
    localparam logic [NUM_W-1:0]      K_ONE    = NUM_W'(1);
    localparam logic [DW-1:0]         D_LAST   = DW'(PIPE_LAT - 1);
    localparam logic [DW-1:0]         D_ONE    = DW'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [NUM_W-1:0]      k, k_n, k_inc;
    logic [WTS_ROM_AW-1:0] base_q, base_n;
    logic [NUM_W-1:0]      num_q, num_n;
    logic [DW-1:0]         drain_cnt, drain_n;
    logic [PIPE_LAT-1:0]   oa_pipe;

    logic                  busy_n, done_n, rd_n, rf_n, en_n;
    logic [WTS_ROM_AW-1:0] rom_n;
    logic [RAM_ADDR_W-1:0] ram_n;
    logic [ARB_W-1:0]      arb_n;
    logic                  last_slot;
    logic                  hold_slot;

`ifdef ADDR_SEQ_STALL_EN
    assign hold_slot = stall;
`else
    assign hold_slot = 1'b0;
`endif

    // The registered enable marks the slot on the bus as issued; a paused
    // slot (enable low) is re-presented until it is actually issued.
    assign oa_valid = oa_pipe[PIPE_LAT-1];

    // Next-state and next-output logic; outputs are registered from it.
    always_comb begin
        state_n   = state;
        k_n       = k;
        base_n    = base_q;
        num_n     = num_q;
        drain_n   = drain_cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        rd_n      = 1'b0;
        rf_n      = 1'b0;
        en_n      = 1'b0;
        rom_n     = wts_rom_addr;
        ram_n     = ram_address;
        arb_n     = arbiter_ctrl;
        k_inc     = k + K_ONE;
        last_slot = addr_bram_enable
                    && (ram_address == RAM_LAST)
                    && (arbiter_ctrl == ARB_LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    base_n = wts_base;
                    num_n  = num_wts;
                    k_n    = '0;
                    if (num_wts == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = FETCH;
                        busy_n  = 1'b1;
                        rd_n    = 1'b1;
                        rom_n   = wts_base;
                    end
                end
            end
            FETCH: begin
                state_n = LOAD;
                rf_n    = 1'b1;
                ram_n   = '0;
                arb_n   = '0;
            end
            LOAD: begin
                state_n = SCAN;
                en_n    = !hold_slot;
            end
            SCAN: begin
                if (last_slot) begin
                    k_n = k_inc;
                    if (k_inc < num_q) begin
                        state_n = FETCH;
                        rd_n    = 1'b1;
                        rom_n   = base_q + WTS_ROM_AW'(k_inc);
                    end else begin
                        state_n = DRAIN;
                        drain_n = '0;
                    end
                end else begin
                    en_n = !hold_slot;
                    if (addr_bram_enable) begin
                        if (ram_address == RAM_LAST) begin
                            ram_n = '0;
                            arb_n = arbiter_ctrl + ARB_ONE;
                        end else begin
                            ram_n = ram_address + RAM_ONE;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == D_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    drain_n = drain_cnt + D_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            k                <= '0;
            base_q           <= '0;
            num_q            <= '0;
            drain_cnt        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            wts_rom_rd_en    <= 1'b0;
            wts_rom_addr     <= '0;
            addr_rf_enable   <= 1'b0;
            addr_bram_enable <= 1'b0;
            ram_address      <= '0;
            arbiter_ctrl     <= '0;
            oa_pipe          <= '0;
        end else begin
            state            <= state_n;
            k                <= k_n;
            base_q           <= base_n;
            num_q            <= num_n;
            drain_cnt        <= drain_n;
            busy             <= busy_n;
            done             <= done_n;
            wts_rom_rd_en    <= rd_n;
            wts_rom_addr     <= rom_n;
            addr_rf_enable   <= rf_n;
            addr_bram_enable <= en_n;
            ram_address      <= ram_n;
            arbiter_ctrl     <= arb_n;
            oa_pipe          <= (oa_pipe << 1)
                                | PIPE_LAT'(addr_bram_enable);
        end
    end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// tb_addr_seq_ctrl: directed bench for addr_seq_ctrl.
// Build with ADDR_SEQ_STALL_EN to also exercise the stall input.
`timescale 1ns/1ps
module tb_addr_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] wts_base;
    logic [9:0] num_wts;
`ifdef ADDR_SEQ_STALL_EN
    logic       stall;
`endif
    logic       busy, done, wts_rom_rd_en, addr_rf_enable;
    logic       addr_bram_enable, oa_valid;
    logic [9:0] wts_rom_addr;
    logic [4:0] ram_address;
    logic [2:0] arbiter_ctrl;

    addr_seq_ctrl dut (
        .clock            (clk),
        .reset            (reset),
        .start            (start),
        .wts_base         (wts_base),
        .num_wts          (num_wts),
`ifdef ADDR_SEQ_STALL_EN
        .stall            (stall),
`endif
        .busy             (busy),
        .done             (done),
        .wts_rom_rd_en    (wts_rom_rd_en),
        .wts_rom_addr     (wts_rom_addr),
        .addr_rf_enable   (addr_rf_enable),
        .addr_bram_enable (addr_bram_enable),
        .ram_address      (ram_address),
        .arbiter_ctrl     (arbiter_ctrl),
        .oa_valid         (oa_valid)
    );

    always #5 clk = ~clk;

    logic [23:0] outs;
    assign outs = {busy, done, wts_rom_rd_en, wts_rom_addr, addr_rf_enable,
                   addr_bram_enable, ram_address, arbiter_ctrl, oa_valid};

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state, sampled on the falling edge.
    int         cyc = 0, n_oa = 0, n_en = 0, n_done = 0, n_rd = 0;
    int         n_busy = 0, rf_ok = 0, scan_err = 0, gap_len = 0;
    int         n_hold = 0;
    logic [7:0] idx = 8'd0;
    logic       prev_rd = 1'b0;
    logic [9:0] rom_q[$];
    int         gap_q[$];

    // Snapshots taken at the start of each scenario.
    int s_cyc, s_oa, s_en, s_done, s_rd, s_busy, s_rf, s_err, s_hold;
    int s_rq, s_gq, done_at;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (oa_valid)         n_oa   <= n_oa + 1;
        if (addr_bram_enable) n_en   <= n_en + 1;
        if (done)             n_done <= n_done + 1;
        if (busy)             n_busy <= n_busy + 1;
        if (wts_rom_rd_en) begin
            n_rd <= n_rd + 1;
            rom_q.push_back(wts_rom_addr);
        end
        prev_rd <= wts_rom_rd_en;
        if (addr_rf_enable && prev_rd) rf_ok <= rf_ok + 1;
        if (addr_rf_enable) begin
            idx <= 8'd0;
        end else if (addr_bram_enable) begin
            if ({arbiter_ctrl, ram_address} !== idx) scan_err <= scan_err + 1;
            idx <= idx + 8'd1;
        end
        if (busy && !addr_bram_enable && ram_address == 5'd7
            && arbiter_ctrl == 3'd0)
            n_hold <= n_hold + 1;
        if (!busy) begin
            gap_len <= 0;
        end else if (!addr_bram_enable) begin
            gap_len <= gap_len + 1;
        end else if (gap_len != 0) begin
            gap_q.push_back(gap_len);
            gap_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_cyc  = cyc;
        s_oa   = n_oa;
        s_en   = n_en;
        s_done = n_done;
        s_rd   = n_rd;
        s_busy = n_busy;
        s_rf   = rf_ok;
        s_err  = scan_err;
        s_hold = n_hold;
        s_rq   = rom_q.size();
        s_gq   = gap_q.size();
    endtask

    task automatic start_seq(input logic [9:0] base, input logic [9:0] num);
        @(negedge clk);
        #1;
        snap();
        wts_base = base;
        num_wts  = num;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_done != s_done) begin
                done_at = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            done_at = -1;
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic wait_slot(input string tag, input logic [4:0] r,
                             input logic [2:0] a, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (addr_bram_enable && ram_address == r && arbiter_ctrl == a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) chk({tag, "_slot_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        wts_base = '0;
        num_wts  = '0;
`ifdef ADDR_SEQ_STALL_EN
        stall    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", 32'(outs), 32'd0);
        reset = 1'b1;

        // Single weight: 2 + 256 + 3 + 1 cycles to done.
        start_seq(10'h010, 10'd1);
        wait_done("t1", 400);
        chk("t1_lat", done_at - s_cyc, 262);
        chk("t1_oa", n_oa - s_oa, 256);
        chk("t1_en", n_en - s_en, 256);
        chk("t1_nrd", n_rd - s_rd, 1);
        chk("t1_rom0", 32'(rom_q[s_rq]), 32'h010);
        chk("t1_rf", rf_ok - s_rf, 1);
        chk("t1_order", scan_err - s_err, 0);
        chk("t1_ngap", gap_q.size() - s_gq, 1);
        chk("t1_gap0", gap_q[s_gq], 2);
        repeat (5) @(negedge clk);
        #1;
        chk("t1_oa_after", n_oa - s_oa, 256);
        chk("t1_ndone", n_done - s_done, 1);

        // Three weights with ROM address wrap.
        start_seq(10'h3FF, 10'd3);
        wait_done("t2", 1000);
        chk("t2_lat", done_at - s_cyc, 778);
        chk("t2_oa", n_oa - s_oa, 768);
        chk("t2_nrd", n_rd - s_rd, 3);
        chk("t2_rom0", 32'(rom_q[s_rq]), 32'h3FF);
        chk("t2_rom1", 32'(rom_q[s_rq+1]), 32'h000);
        chk("t2_rom2", 32'(rom_q[s_rq+2]), 32'h001);
        chk("t2_rf", rf_ok - s_rf, 3);
        chk("t2_order", scan_err - s_err, 0);
        chk("t2_ngap", gap_q.size() - s_gq, 3);
        for (int i = 0; i < 3; i++) chk("t2_gap", gap_q[s_gq+i], 2);
        repeat (5) @(negedge clk);
        #1;
        chk("t2_ndone", n_done - s_done, 1);

        // Zero weights: done right after acceptance, nothing else.
        start_seq(10'h055, 10'd0);
        wait_done("t3", 20);
        chk("t3_lat", done_at - s_cyc, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("t3_nrd", n_rd - s_rd, 0);
        chk("t3_en", n_en - s_en, 0);
        chk("t3_oa", n_oa - s_oa, 0);
        chk("t3_busy", n_busy - s_busy, 0);
        chk("t3_ndone", n_done - s_done, 1);

        // Reset in the middle of SCAN, then a clean rerun.
        start_seq(10'h020, 10'd1);
        wait_slot("t4", 5'd10, 3'd4, 400);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_outs", 32'(outs), 32'd0);
        reset = 1'b1;
        snap();
        repeat (10) @(negedge clk);
        #1;
        chk("t4_ndone", n_done - s_done, 0);
        chk("t4_oa", n_oa - s_oa, 0);
        chk("t4_busy", n_busy - s_busy, 0);
        start_seq(10'h020, 10'd1);
        wait_done("t4b", 400);
        chk("t4b_lat", done_at - s_cyc, 262);
        chk("t4b_oa", n_oa - s_oa, 256);
        chk("t4b_rom0", 32'(rom_q[s_rq]), 32'h020);
        chk("t4b_order", scan_err - s_err, 0);

        // Start pulses during SCAN and during DONE are ignored.
        start_seq(10'h100, 10'd1);
        wait_slot("t5", 5'd3, 3'd1, 400);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done("t5", 400);
        chk("t5_lat", done_at - s_cyc, 262);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("t5_ndone", n_done - s_done, 1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_nrd", n_rd - s_rd, 1);

`ifdef ADDR_SEQ_STALL_EN
        // Five stalled slots at ram_address 7 delay done by five cycles.
        start_seq(10'h000, 10'd1);
        wait_slot("t6", 5'd6, 3'd0, 400);
        stall = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        stall = 1'b0;
        wait_done("t6", 400);
        chk("t6_lat", done_at - s_cyc, 267);
        chk("t6_oa", n_oa - s_oa, 256);
        chk("t6_en", n_en - s_en, 256);
        chk("t6_hold", n_hold - s_hold, 5);
        chk("t6_order", scan_err - s_err, 0);
        chk("t6_ngap", gap_q.size() - s_gq, 2);
        chk("t6_gap1", gap_q[s_gq+1], 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_seq_ctrl.md
Name: addr_seq_ctrl

Overview:
- Sequencer for the address path (IA address BRAMs, arbiters, weight-address register file, address array).
- For each weight, it fetches the weight address word from the weights ROM and loads it into the address register file.
- It then sweeps every IA BRAM address under every arbiter setting and flags the cycles on which the address array outputs carry valid OA row/col/ch addresses.
- It sits between the top-level layer controller (start/done) and the address module's control inputs.

Parameters:
- RAM_ADDR_W, 5, width of ram_address to the IA row/col BRAMs
- RAM_DEPTH, 32, number of BRAM entries swept per arbiter setting (≤ 2^RAM_ADDR_W)
- ARB_W, 3, width of arbiter_ctrl
- ARB_SEL, 8, number of arbiter settings swept (≤ 2^ARB_W)
- WTS_ROM_AW, 10, weights ROM address width
- NUM_W, 10, width of the num_wts count input
- PIPE_LAT, 3, cycles from addr_bram_enable to valid address array outputs

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- wts_base  in  WTS_ROM_AW  first weights ROM address; latched on accepted start
- num_wts  in  NUM_W  number of weights to process; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of sequence
- wts_rom_rd_en  out  1  weights ROM read strobe
- wts_rom_addr  out  WTS_ROM_AW  weights ROM address
- addr_rf_enable  out  1  capture strobe for the address register file
- addr_bram_enable  out  1  IA BRAM enable
- ram_address  out  RAM_ADDR_W  IA BRAM address
- arbiter_ctrl  out  ARB_W  IA arbiter select
- oa_valid  out  1  address array outputs valid this cycle

Behaviour:
- All outputs are registered.
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs go to 0; counters, the latched wts_base/num_wts and the oa_valid shift register are cleared.
  - This applies mid-operation as well: an in-flight sequence is discarded, with no done pulse and no further oa_valid.
- States: IDLE, FETCH, LOAD, SCAN, DRAIN, DONE.
- IDLE:
  - start==1 latches wts_base and num_wts, clears the weight counter k, and asserts busy.
  - If num_wts==0, go to DONE; otherwise go to FETCH.
- FETCH (1 cycle): wts_rom_rd_en=1, wts_rom_addr=wts_base+k (modulo 2^WTS_ROM_AW, wraps silently). Next state is LOAD.
- LOAD (1 cycle): addr_rf_enable=1, because ROM data is valid one cycle after the read. Clear ram_address and arbiter_ctrl, then go to SCAN.
- SCAN, each cycle:
  - addr_bram_enable=1.
  - ram_address increments; at RAM_DEPTH-1 it wraps to 0 and arbiter_ctrl increments.
  - The last scan cycle is ram_address==RAM_DEPTH-1 with arbiter_ctrl==ARB_SEL-1. On that cycle k increments; if k+1<num_wts go to FETCH, else go to DRAIN.
  - Each weight therefore costs 2 + RAM_DEPTH*ARB_SEL cycles.
- Idle values: addr_bram_enable, wts_rom_rd_en and addr_rf_enable are 0 outside their states. ram_address and arbiter_ctrl hold their last value outside SCAN.
- DRAIN: wait PIPE_LAT cycles, counted from entry, then go to DONE.
- DONE (1 cycle): done=1, busy=0 on the same cycle, next state is IDLE.
- oa_valid is addr_bram_enable delayed by PIPE_LAT cycles through a shift register. Its last pulse occurs during DRAIN, no later than the DONE cycle.
- start outside IDLE is ignored; no queuing.
- Between weights the sweep has 2 bubble cycles (FETCH, LOAD) during which addr_bram_enable=0.

Optional Feature:
- Macro ADDR_SEQ_STALL_EN. When defined, adds input port stall (1 bit).
- While stall==1 in SCAN:
  - addr_bram_enable=0.
  - ram_address, arbiter_ctrl and k hold.
  - oa_valid carries 0 for that slot.
- stall is ignored in all other states.
- When not defined, there is no stall port and SCAN never pauses.

Test Plan:
1. Reset, then start with wts_base=0x010, num_wts=1 (defaults) → FETCH reads addr 0x010, addr_rf_enable pulses on the next cycle, then 256 SCAN cycles (ram_address 0..31 within each arbiter_ctrl 0..7). Exactly 256 oa_valid pulses; done 2+256+3+1=262 cycles after start acceptance.
2. num_wts=3, wts_base=0x3FF → ROM reads 0x3FF, 0x000, 0x001 (wrap). Exactly 2 addr_bram_enable=0 bubbles between sweeps; 768 oa_valid pulses; one done pulse.
3. num_wts=0 → done pulses the cycle after acceptance; no wts_rom_rd_en, addr_bram_enable or oa_valid.
4. reset driven low at SCAN ram_address=10, arbiter_ctrl=4 → next cycle all outputs 0, state IDLE, no done. A new start then runs a complete, correct sequence.
5. start pulsed during SCAN and during DONE → ignored; only one done pulse per accepted start.
6. (ADDR_SEQ_STALL_EN) stall high for 5 cycles at ram_address=7 → ram_address stays 7 and addr_bram_enable=0 for 5 cycles. Total oa_valid count is still 256 and done arrives 5 cycles later.
